// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath register file.
//
// Contents:
//   DATA_W_DEF / ADDR_W_DEF : default entry width and address width
//   ST_IDLE / ST_SWEEP      : encoding of the background-clear FSM
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter for one address.
//
// Given an address, reports whether any enabled write port targets it and,
// if so, the data of the winning port (the highest-index port wins).
// Address 0 never hits when ZERO_REG is set.
//
// Ports:
//   i_addr    : address being resolved
//   i_wr_en   : per-port write enables (already gated by the caller)
//   i_wr_addr : packed write addresses, port j at [j*ADDR_W +: ADDR_W]
//   i_wr_data : packed write data, port j at [j*DATA_W +: DATA_W]
//   o_hit     : some enabled port targets i_addr
//   o_data    : winning write data (0 when no hit)
module regfile_wr_arb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_WR     = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [N_WR-1:0]          i_wr_en,
    input  logic [N_WR*ADDR_W-1:0]   i_wr_addr,
    input  logic [N_WR*DATA_W-1:0]   i_wr_data,
    output logic                     o_hit,
    output logic [DATA_W-1:0]        o_data
);

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        // Ascending scan: a later (higher-index) match overrides earlier ones.
        for (int j = 0; j < N_WR; j++) begin
            if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_wr_data[j*DATA_W +: DATA_W];
            end
        end
        if (ZERO_REG && (i_addr == '0)) begin
            o_hit  = 1'b0;
            o_data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with background clear.
//
// N_RD combinational read ports, N_WR write ports with fixed priority
// (highest index wins), optional same-cycle write-to-read bypass, optional
// hard-wired zero register, and a sweep sequencer that zeroes one entry per
// cycle after a clr_req pulse. While sweeping, writes are dropped and all
// read ports return 0.
//
// Handshake: clr_req is a single-cycle request sampled only in IDLE; there is
// no back-pressure. clr_busy is high for exactly DEPTH cycles of the sweep and
// clr_done pulses for one cycle on the first IDLE cycle afterwards.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rd_addr      : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      : packed read data (combinational), port i at [i*DATA_W +: DATA_W]
//   wr_en        : per-port write enables
//   wr_addr      : packed write addresses
//   wr_data      : packed write data
//   clr_req      : start a background clear
//   clr_busy     : sweep in progress
//   clr_done     : sweep completed (one-cycle pulse)
//   o_dbg_state  : clear-FSM state (ST_IDLE / ST_SWEEP)
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_RD     = 2,
    parameter int N_WR     = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic [N_WR-1:0]          wr_en,
    input  logic [N_WR*ADDR_W-1:0]   wr_addr,
    input  logic [N_WR*DATA_W-1:0]   wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic [0:0]               o_dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_clr_done;

    logic              w_idle;
    logic [N_WR-1:0]   w_wr_en;
    logic              w_cmt_hit  [DEPTH];
    logic [DATA_W-1:0] w_cmt_data [DEPTH];

    assign w_idle      = (r_state == ST_IDLE);
    // Writes only take effect while no sweep is running.
    assign w_wr_en     = w_idle ? wr_en : '0;
    assign clr_busy    = (r_state == ST_SWEEP);
    assign clr_done    = r_clr_done;
    assign o_dbg_state = r_state;

    // ---------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state <= ST_SWEEP;
                        r_ptr   <= '0;
                    end
                end
                ST_SWEEP: begin
                    // Natural wrap brings the pointer back to 0 on exit.
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == '1) begin
                        r_state    <= ST_IDLE;
                        r_clr_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Commit arbitration: one resolver per array entry
    // ---------------------------------------------------------------
    for (genvar e = 0; e < DEPTH; e++) begin : g_cmt
        regfile_wr_arb #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .N_WR     (N_WR),
            .ZERO_REG (ZERO_REG)
        ) u_arb (
            .i_addr    (ADDR_W'(e)),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_hit     (w_cmt_hit[e]),
            .o_data    (w_cmt_data[e])
        );
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (rst) begin
                r_mem[e] <= '0;
            end else if (clr_busy && (r_ptr == ADDR_W'(e))) begin
                r_mem[e] <= '0;
            end else if (w_cmt_hit[e]) begin
                r_mem[e] <= w_cmt_data[e];
            end
        end
    end

    // ---------------------------------------------------------------
    // Read ports, each with its own bypass resolver
    // ---------------------------------------------------------------
    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic              w_byp_hit;
        logic [DATA_W-1:0] w_byp_data;
        logic [DATA_W-1:0] w_rd;

        assign w_raddr = rd_addr[i*ADDR_W +: ADDR_W];

        regfile_wr_arb #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .N_WR     (N_WR),
            .ZERO_REG (ZERO_REG)
        ) u_byp (
            .i_addr    (w_raddr),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_hit     (w_byp_hit),
            .o_data    (w_byp_data)
        );

        always_comb begin
            w_rd = r_mem[w_raddr];
            if (BYPASS && w_byp_hit) begin
                w_rd = w_byp_data;
            end
            // Busy masking and the zero register take precedence over all.
            if (clr_busy || (ZERO_REG && (w_raddr == '0))) begin
                w_rd = '0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = w_rd;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU datapath; the generalised successor of the fixed 32x8, 2-read/1-write register file.
- Adds configurable width, depth and port counts, multiple write ports with fixed priority, optional write-to-read bypass and an optional hard-wired zero register.
- Adds a background clear sequencer that zeroes the array one entry per cycle without asserting reset.
- Sits between decode (addresses) and ALU/writeback (data).

Parameters:
- DATA_W, 8, bits per entry.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- N_RD, 2, number of read ports (1..4).
- N_WR, 2, number of write ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is visible on the read port; 0 = read returns the pre-write array value.
- ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rd_addr  in  N_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data, combinational; port i occupies bits [i*DATA_W +: DATA_W]
- wr_en  in  N_WR  per-port write enable
- wr_addr  in  N_WR*ADDR_W  write addresses, same packing as rd_addr
- wr_data  in  N_WR*DATA_W  write data, same packing as rd_data
- clr_req  in  1  single-cycle pulse that starts a background clear
- clr_busy  out  1  high while the sweep runs
- clr_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Clocking: single clock clk; rst is synchronous, active-high.
- Reset:
  - On any clk edge with rst=1, all DEPTH entries go to 0, the FSM goes to IDLE, the sweep pointer goes to 0, and clr_busy=0, clr_done=0.
  - rst overrides all writes and clr_req in that cycle.
  - rst asserted mid-sweep aborts the sweep; no clr_done is issued.
- Writes:
  - Port j writes wr_data[j] to wr_addr[j] on the clk edge when wr_en[j]=1 and the FSM is IDLE.
  - If several enabled ports target the same address, the highest-index port wins; the others are dropped.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads:
  - Combinational, zero latency.
  - With BYPASS=1, if any enabled write port targets rd_addr[i] in the same cycle, rd_data[i] returns the winning write data. Bypass follows the same priority rules as the write and never applies to address 0 when ZERO_REG=1.
  - With BYPASS=0, rd_data[i] returns the current array contents.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when clr_req=1; the pointer loads 0.
  - In SWEEP, each cycle writes 0 to entry[ptr] and increments ptr.
  - After the cycle that clears entry DEPTH-1, the FSM returns to IDLE. clr_done pulses high for exactly one cycle, the first cycle back in IDLE.
  - A sweep takes DEPTH cycles; clr_busy is high for exactly those DEPTH cycles.
  - clr_req while in SWEEP is ignored; the sweep does not restart.
  - clr_req and wr_en in the same IDLE cycle: the write commits, then the sweep begins next cycle and clears it.
  - While clr_busy=1: all wr_en are ignored, bypass is disabled, and every rd_data port returns 0.
- Pointer width is ADDR_W; the pointer wraps to 0 at SWEEP exit and holds in IDLE.
- Widths are exact; no truncation or extension of write data.

Decomposition:
- Shared package (cpu_pkg): data-width and address-width defaults, and the clear-FSM state encoding (IDLE=1'b0, SWEEP=1'b1).
- One natural sub-module: regfile_wr_arb. It is combinational and, for a given address, resolves the winning write port (hit flag + data). It is instanced once per read port for bypass and once per array entry, or once per write port, for commit.
- The sweep FSM stays inline in regfile_mp.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then rd_addr[0]=5, rd_addr[1]=31 -> both rd_data=8'h00; clr_busy=0.
- Conflicting writes: wr_en=2'b11, wr_addr={7,7}, wr_data={8'hBB,8'hAA}, one cycle -> entry 7 = 8'hBB (port 1 wins); a next-cycle read of 7 returns 8'hBB.
- Bypass: with BYPASS=1, in the same cycle write 8'h5A to addr 3 and read addr 3 -> rd_data=8'h5A that cycle. With BYPASS=0 -> old value (8'h00) that cycle, 8'h5A the next.
- Zero register: with ZERO_REG=1, write 8'hFF to addr 0 -> reads of addr 0 return 8'h00, both same-cycle and afterwards.
- Background clear:
  - Setup: fill entries with nonzero values, pulse clr_req.
  - clr_busy is high for exactly 32 cycles and writes in that window are ignored.
  - clr_done pulses once in cycle 33; all entries then read 8'h00.
  - A second clr_req during the sweep has no effect.
- Reset mid-sweep: pulse clr_req, assert rst at sweep cycle 10 -> next cycle clr_busy=0, no clr_done pulse, all entries 0; a write to addr 4 immediately after reset is accepted.
